// File: rtl/lfsr_arb.sv
// Two-requester round-robin front end for an external LFSR: seed loads and byte bursts.
// Optional macro LFSR_ZERO_GUARD_EN keeps the LFSR out of the all-zero lock-up state.
module lfsr_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        ld0,
    input  logic        ld1,
    input  logic [31:0] seed0,
    input  logic [31:0] seed1,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        byte_id,
    input  logic        byte_rdy,
    output logic [31:0] ldVal,
    output logic        ldLFSR,
    output logic        step,
    input  logic [7:0]  psrByte,
    input  logic [31:0] lfsrVal
);

    typedef enum logic [1:0] {IDLE, LOAD, BURST, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic [31:0] seed_q, seed_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        byte_id_q, byte_id_d;

    logic        pick1;
    logic        sel_ld;
    logic [31:0] sel_seed;
    logic [7:0]  sel_len;
    logic        slot_free;
    logic        zero_stall;
    logic [31:0] load_val;
    logic        ld_lfsr_c;
    logic        step_c;
    logic [31:0] ld_val_c;

    // rr_q holds the last requester served; on a tie the other one wins.
    assign pick1     = req1 && (!req0 || !rr_q);
    assign sel_ld    = pick1 ? ld1   : ld0;
    assign sel_seed  = pick1 ? seed1 : seed0;
    assign sel_len   = pick1 ? len1  : len0;
    assign slot_free = !byte_valid_q || byte_rdy;

`ifdef LFSR_ZERO_GUARD_EN
    assign zero_stall = (state_q == BURST) && (remaining_q != 8'd0) && (lfsrVal == 32'd0);
    assign load_val   = (seed_q == 32'd0) ? 32'h0000_0001 : seed_q;
`else
    logic unused_lfsr_val;
    assign unused_lfsr_val = ^lfsrVal;
    assign zero_stall      = 1'b0;
    assign load_val        = seed_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    if (sel_ld) begin
                        state_d = LOAD;
                    end else if (sel_len != 8'd0) begin
                        state_d = BURST;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD:  state_d = DONE;
            BURST: begin
                if (remaining_q == 8'd0 && slot_free) begin
                    state_d = DONE;
                end
            end
            DONE:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_lfsr_c = 1'b0;
        step_c    = 1'b0;
        ld_val_c  = '0;
        unique case (state_q)
            LOAD: begin
                ld_lfsr_c = 1'b1;
                ld_val_c  = load_val;
            end
            BURST: begin
                // A zero LFSR is reseeded in place; remaining is untouched so the burst resumes.
                if (zero_stall) begin
                    ld_lfsr_c = 1'b1;
                    ld_val_c  = 32'h0000_0001;
                end else begin
                    step_c = (remaining_q != 8'd0) && slot_free;
                end
            end
            default: begin
            end
        endcase
    end

    assign ldLFSR     = ld_lfsr_c;
    assign step       = step_c;
    assign ldVal      = ld_val_c;
    assign gnt0       = (state_q != IDLE) && !owner_q;
    assign gnt1       = (state_q != IDLE) &&  owner_q;
    assign done0      = (state_q == DONE) && !owner_q;
    assign done1      = (state_q == DONE) &&  owner_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_id    = byte_id_q;

    always_comb begin
        owner_d      = owner_q;
        rr_d         = rr_q;
        seed_d       = seed_q;
        remaining_d  = remaining_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        byte_id_d    = byte_id_q;

        if (state_q == IDLE && (req0 || req1)) begin
            owner_d     = pick1;
            seed_d      = sel_seed;
            remaining_d = sel_ld ? 8'd0 : sel_len;
        end

        if (state_q == DONE) begin
            rr_d = owner_q;
        end

        // The captured byte is the LFSR output before this step advances it.
        if (step_c) begin
            remaining_d  = remaining_q - 8'd1;
            byte_out_d   = psrByte;
            byte_valid_d = 1'b1;
            byte_id_d    = owner_q;
        end else if (byte_valid_q && byte_rdy) begin
            byte_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q      <= 1'b0;
            rr_q         <= 1'b1;
            seed_q       <= '0;
            remaining_q  <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            byte_id_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            seed_q       <= seed_d;
            remaining_q  <= remaining_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_id_q    <= byte_id_d;
        end
    end

endmodule
